fifo_uart_tx: RTL

//  Downstream drain stage for the byte FIFO: pops 8-bit words from the FIFO

---
 rtl/fifo_uart_tx_if.sv | 22 ++
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side and serial-line signals of the UART drain stage.
// slave = the drain stage itself; master = whoever owns the FIFO and observes the line.
interface fifo_uart_tx_if;
    logic        TxEn;
    logic        FifoEmpty;
    logic [7:0]  FifoData;
    logic        FifoRd;
    logic        TxD;
    logic        Busy;
    logic        FrameDone;
    logic [15:0] TxCount;

    modport master (
        output TxEn, FifoEmpty, FifoData,
        input  FifoRd, TxD, Busy, FrameDone, TxCount
    );

    modport slave (
        input  TxEn, FifoEmpty, FifoData,
        output FifoRd, TxD, Busy, FrameDone, TxCount
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and sends each as one UART frame; latency RD_LATENCY
// cycles from non-empty to pop, frame starts the cycle after; stalls in IDLE while empty or TxEn=0.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int RD_LATENCY   = 2,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    fifo_uart_tx_if.slave bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LATENCY - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud, baud_nxt;
    logic [LW-1:0] lat, lat_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par, par_nxt;
    logic [15:0]   tx_count, count_nxt;
    logic          txd, txd_nxt;
    logic          fifo_rd, fifo_rd_nxt;
    logic          busy, busy_nxt;
    logic          frame_done, frame_done_nxt;
    logic          baud_end;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            baud       <= '0;
            lat        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            tx_count   <= '0;
            txd        <= 1'b1;
            fifo_rd    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud       <= baud_nxt;
            lat        <= lat_nxt;
            bit_idx    <= bit_nxt;
            shift      <= shift_nxt;
            par        <= par_nxt;
            tx_count   <= count_nxt;
            txd        <= txd_nxt;
            fifo_rd    <= fifo_rd_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud + BW'(1);
        lat_nxt   = lat;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        par_nxt   = par;
        count_nxt = tx_count;
        baud_end  = (baud == BAUD_LAST);

        case (state)
            S_IDLE: begin
                baud_nxt = '0;
                if (bus.TxEn && !bus.FifoEmpty) begin
                    state_nxt = S_WAIT;
                    lat_nxt   = '0;
                end
            end
            S_WAIT: begin
                baud_nxt = '0;
                if (bus.FifoEmpty) begin
                    state_nxt = S_IDLE;
                end else if (lat == LAT_LAST) begin
                    shift_nxt = bus.FifoData;
                    par_nxt   = (^bus.FifoData) ^ PAR_ODD;
                    state_nxt = S_START;
                end else begin
                    lat_nxt = lat + LW'(1);
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_nxt = S_DATA;
                    bit_nxt   = '0;
                    baud_nxt  = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    shift_nxt = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_nxt = S_STOP;
                    bit_nxt   = '0;
                    baud_nxt  = '0;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx == STOP_LAST) begin
                        count_nxt = tx_count + 16'd1;
                        lat_nxt   = '0;
                        // Chain straight into the next pop so frames run back to back.
                        state_nxt = (bus.TxEn && !bus.FifoEmpty) ? S_WAIT : S_IDLE;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so the flops line up with the state they describe.
    always_comb begin
        case (state_nxt)
            S_START:  txd_nxt = 1'b0;
            S_DATA:   txd_nxt = shift_nxt[0];
            S_PARITY: txd_nxt = par_nxt;
            default:  txd_nxt = 1'b1;
        endcase
        busy_nxt       = (state_nxt != S_IDLE);
        fifo_rd_nxt    = (state_nxt == S_WAIT) && (lat_nxt == LAT_LAST);
        frame_done_nxt = (state_nxt == S_STOP) && (bit_nxt == STOP_LAST) && (baud_nxt == BAUD_LAST);
    end

    assign bus.TxD       = txd;
    assign bus.FifoRd    = fifo_rd;
    assign bus.Busy      = busy;
    assign bus.FrameDone = frame_done;
    assign bus.TxCount   = tx_count;
endmodule
